// File: rtl/gpio_in_filter_pkg.sv
// Shared types and constants for the GPIO input conditioning stage.
package gpio_in_filter_pkg;

  localparam int GPIO_FLT_CNT_W = 16;

  typedef enum logic {
    GPIO_FLT_STABLE   = 1'b0,
    GPIO_FLT_SETTLING = 1'b1
  } type_gpio_flt_state_e;

endpackage

// File: rtl/gpio_in_filter_if.sv
// Pad-side / config bundle for the GPIO input filter.
// Level signals only, no valid/ready: every field is sampled or driven on every clk cycle.
interface gpio_in_filter_if #(
  parameter int NUM_PINS = 8,
  parameter int CNT_W    = 16
);
  logic [NUM_PINS-1:0] pin_i;
  logic [NUM_PINS-1:0] db_en_i;
  logic [CNT_W-1:0]    db_limit_i;
  logic [NUM_PINS-1:0] pin_o;
  logic [NUM_PINS-1:0] rise_o;
  logic [NUM_PINS-1:0] fall_o;
  logic [NUM_PINS-1:0] settling_o;

  modport master (
    output pin_i, db_en_i, db_limit_i,
    input  pin_o, rise_o, fall_o, settling_o
  );

  modport slave (
    input  pin_i, db_en_i, db_limit_i,
    output pin_o, rise_o, fall_o, settling_o
  );
endinterface

// File: rtl/gpio_in_filter_pin.sv
// One pin: synchroniser, STABLE/SETTLING debounce FSM with saturating counter, edge detect.
module gpio_pin_filter
  import gpio_in_filter_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = GPIO_FLT_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pin_i,
  input  logic                 db_en_i,
  input  logic [CNT_W-1:0]     db_limit_i,
  output logic                 pin_o,
  output logic                 rise_o,
  output logic                 fall_o,
  output type_gpio_flt_state_e state_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  type_gpio_flt_state_e   state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       eff_lim;
  logic                   pin_q, pin_d;
  logic                   pin_dly_q;

  assign s = sync_q[SYNC_STAGES-1];

  // A limit of zero would accept instantly; treat it as one cycle.
  assign eff_lim = (db_limit_i == '0) ? CNT_W'(1) : db_limit_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      state_q   <= GPIO_FLT_STABLE;
      cnt_q     <= '0;
      pin_q     <= 1'b0;
      pin_dly_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], pin_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pin_q     <= pin_d;
      pin_dly_q <= pin_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pin_d   = pin_q;
    if (!db_en_i) begin
      state_d = GPIO_FLT_STABLE;
      cnt_d   = '0;
      pin_d   = s;
    end else begin
      case (state_q)
        GPIO_FLT_STABLE: begin
          if (s != pin_q) begin
            state_d = GPIO_FLT_SETTLING;
            cnt_d   = CNT_W'(1);
          end else begin
            cnt_d = '0;
          end
        end
        GPIO_FLT_SETTLING: begin
          if (s == pin_q) begin
            state_d = GPIO_FLT_STABLE;
            cnt_d   = '0;
          end else if (cnt_q >= eff_lim) begin
            // >= so a limit lowered mid-settle below cnt accepts right away.
            state_d = GPIO_FLT_STABLE;
            cnt_d   = '0;
            pin_d   = s;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = GPIO_FLT_STABLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign pin_o   = pin_q;
  assign rise_o  = pin_q & ~pin_dly_q;
  assign fall_o  = ~pin_q & pin_dly_q;
  assign state_o = state_q;

endmodule

// File: rtl/gpio_in_filter.sv
// GPIO input conditioning: NUM_PINS fully independent per-pin debounce filters.
module gpio_in_filter
  import gpio_in_filter_pkg::*;
#(
  parameter int NUM_PINS    = 8,
  parameter int SYNC_STAGES = 2,  // legal range 2..4
  parameter int CNT_W       = GPIO_FLT_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  gpio_in_filter_if.slave bus
);

  logic [NUM_PINS-1:0]  pin_v;
  logic [NUM_PINS-1:0]  rise_v;
  logic [NUM_PINS-1:0]  fall_v;
  logic [NUM_PINS-1:0]  settle_v;
  type_gpio_flt_state_e state_v [NUM_PINS];

  for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
    gpio_pin_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W)
    ) u_pin (
      .clk       (clk),
      .rst_n     (rst_n),
      .pin_i     (bus.pin_i[i]),
      .db_en_i   (bus.db_en_i[i]),
      .db_limit_i(bus.db_limit_i),
      .pin_o     (pin_v[i]),
      .rise_o    (rise_v[i]),
      .fall_o    (fall_v[i]),
      .state_o   (state_v[i])
    );
    assign settle_v[i] = (state_v[i] == GPIO_FLT_SETTLING);
  end

  assign bus.pin_o      = pin_v;
  assign bus.rise_o     = rise_v;
  assign bus.fall_o     = fall_v;
  assign bus.settling_o = settle_v;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Bench for gpio_in_filter: run-length reference model compared every cycle plus directed literal checks.
module tb_gpio_in_filter;

  localparam int NP   = 8;
  localparam int SYNC = 2;
  localparam int CW   = 16;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  logic [31:0] exp_q[$];

  gpio_in_filter_if #(.NUM_PINS(NP), .CNT_W(CW)) bus ();

  gpio_in_filter #(
    .NUM_PINS   (NP),
    .SYNC_STAGES(SYNC),
    .CNT_W      (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // A new level is accepted once the synchronised input has disagreed with the
  // filtered level for eff_lim+1 consecutive enabled edges; bypass copies it.
  logic [NP-1:0] hist [SYNC];
  logic [NP-1:0] m_pin;
  int            run  [NP];

  always @(posedge clk or negedge rst_n) begin : model
    logic [NP-1:0] s, pn, sn;
    int            rn [NP];
    int            lim;
    if (!rst_n) begin
      foreach (hist[j]) hist[j] <= '0;
      foreach (run[j])  run[j]  <= 0;
      m_pin <= '0;
      exp_q.delete();
    end else begin
      s   = hist[SYNC-1];
      lim = (bus.db_limit_i == 0) ? 1 : int'(bus.db_limit_i);
      pn  = m_pin;
      sn  = '0;
      for (int i = 0; i < NP; i++) begin
        rn[i] = 0;
        if (!bus.db_en_i[i]) begin
          pn[i] = s[i];
        end else if (s[i] != m_pin[i]) begin
          if (run[i] + 1 >= lim + 1) pn[i] = s[i];
          else rn[i] = run[i] + 1;
        end
        sn[i] = (rn[i] != 0);
      end
      exp_q.push_back({sn, ~pn & m_pin, pn & ~m_pin, pn});
      for (int i = 0; i < NP; i++) run[i] <= rn[i];
      m_pin   <= pn;
      hist[0] <= bus.pin_i;
      for (int j = 1; j < SYNC; j++) hist[j] <= hist[j-1];
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin : compare
    logic [31:0] e;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("model pin_o",      {24'h0, bus.pin_o},      {24'h0, e[7:0]});
      check("model rise_o",     {24'h0, bus.rise_o},     {24'h0, e[15:8]});
      check("model fall_o",     {24'h0, bus.fall_o},     {24'h0, e[23:16]});
      check("model settling_o", {24'h0, bus.settling_o}, {24'h0, e[31:24]});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sample_after(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic chk8(input string name, input logic [NP-1:0] act, input logic [NP-1:0] exp);
    check(name, {24'h0, act}, {24'h0, exp});
  endtask

  task automatic chk_all_zero(input string tag);
    chk8({tag, " pin_o"},      bus.pin_o,      8'h00);
    chk8({tag, " rise_o"},     bus.rise_o,     8'h00);
    chk8({tag, " fall_o"},     bus.fall_o,     8'h00);
    chk8({tag, " settling_o"}, bus.settling_o, 8'h00);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : stim
    logic seen_pin, seen_rise, seen_settle;
    n_pass  = 0;
    n_total = 0;
    rst_n          = 1'b0;
    bus.pin_i      = 8'hFF;
    bus.db_en_i    = 8'hFF;
    bus.db_limit_i = 16'd4;

    // 1: pads high through reset, then rise after 2+4+1 edges
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk_all_zero("in reset");
    rst_n = 1'b1;
    #1;
    chk_all_zero("at release");
    sample_after(6);
    chk8("t1 pin_o edge6", bus.pin_o, 8'h00);
    chk8("t1 settling edge6", bus.settling_o, 8'hFF);
    sample_after(1);
    chk8("t1 pin_o edge7", bus.pin_o, 8'hFF);
    chk8("t1 rise_o edge7", bus.rise_o, 8'hFF);
    sample_after(1);
    chk8("t1 rise_o edge8", bus.rise_o, 8'h00);

    // 2: 3-cycle glitch on pin 0 rejected with limit 4
    bus.pin_i = 8'h00;
    sample_after(12);
    chk8("t2 pins low", bus.pin_o, 8'h00);
    bus.pin_i   = 8'h01;
    seen_pin    = 1'b0;
    seen_rise   = 1'b0;
    seen_settle = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (k == 3) bus.pin_i = 8'h00;
      sample_after(1);
      seen_pin    |= bus.pin_o[0];
      seen_rise   |= bus.rise_o[0];
      seen_settle |= bus.settling_o[0];
    end
    check("t2 pin_o[0] never high", {31'h0, seen_pin}, 32'd0);
    check("t2 rise_o[0] never", {31'h0, seen_rise}, 32'd0);
    check("t2 settling_o[0] seen", {31'h0, seen_settle}, 32'd1);

    // 3: bypass, 3-edge latency, 1-cycle glitch passes
    bus.db_en_i = 8'h00;
    bus.pin_i   = 8'h08;
    sample_after(2);
    chk8("t3 pin_o edge2", bus.pin_o, 8'h00);
    sample_after(1);
    chk8("t3 pin_o edge3", bus.pin_o, 8'h08);
    chk8("t3 rise_o edge3", bus.rise_o, 8'h08);
    bus.pin_i = 8'h00;
    sample_after(2);
    chk8("t3 pin_o hold", bus.pin_o, 8'h08);
    sample_after(1);
    chk8("t3 pin_o fell", bus.pin_o, 8'h00);
    chk8("t3 fall_o", bus.fall_o, 8'h08);
    bus.pin_i = 8'h08;
    sample_after(1);
    bus.pin_i = 8'h00;
    sample_after(2);
    chk8("t3 glitch pin_o", bus.pin_o, 8'h08);
    chk8("t3 glitch rise_o", bus.rise_o, 8'h08);
    sample_after(1);
    chk8("t3 glitch gone", bus.pin_o, 8'h00);
    chk8("t3 glitch fall_o", bus.fall_o, 8'h08);

    // 4: limit 100 lowered to 10 when cnt = 50
    bus.db_en_i    = 8'hFF;
    bus.db_limit_i = 16'd100;
    sample_after(2);
    chk8("t4 no pulse on enable", bus.rise_o | bus.fall_o, 8'h00);
    bus.pin_i = 8'h02;
    sample_after(52);
    chk8("t4 pin_o cnt50", bus.pin_o, 8'h00);
    chk8("t4 settling cnt50", bus.settling_o, 8'h02);
    bus.db_limit_i = 16'd10;
    sample_after(1);
    chk8("t4 pin_o accepted", bus.pin_o, 8'h02);
    chk8("t4 rise_o", bus.rise_o, 8'h02);
    chk8("t4 settling cleared", bus.settling_o, 8'h00);

    // 5: async reset mid-settle (cnt = 5), then full latency restarts
    bus.db_limit_i = 16'd8;
    bus.pin_i      = 8'h06;
    sample_after(7);
    chk8("t5 settling cnt5", bus.settling_o, 8'h04);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t5 async reset");
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    sample_after(10);
    chk8("t5 pin_o edge10", bus.pin_o, 8'h00);
    sample_after(1);
    chk8("t5 pin_o edge11", bus.pin_o, 8'h06);
    chk8("t5 rise_o edge11", bus.rise_o, 8'h06);

    // 6: limit 0 acts as 1 -> 4 edges, other pins undisturbed
    bus.db_limit_i = 16'd0;
    bus.pin_i      = 8'h86;
    sample_after(3);
    chk8("t6 pin_o edge3", bus.pin_o, 8'h06);
    sample_after(1);
    chk8("t6 pin_o edge4", bus.pin_o, 8'h86);
    chk8("t6 rise_o edge4", bus.rise_o, 8'h80);
    chk8("t6 fall_o edge4", bus.fall_o, 8'h00);

    // 7: enable dropped mid-settle aborts and follows s; re-enable is silent
    bus.db_limit_i = 16'd20;
    bus.pin_i      = 8'h96;
    sample_after(5);
    chk8("t7 settling pin4", bus.settling_o, 8'h10);
    chk8("t7 pin_o held", bus.pin_o, 8'h86);
    bus.db_en_i = 8'hEF;
    sample_after(1);
    chk8("t7 pin_o follows", bus.pin_o, 8'h96);
    chk8("t7 rise_o", bus.rise_o, 8'h10);
    chk8("t7 settling off", bus.settling_o, 8'h00);
    bus.db_en_i = 8'hFF;
    sample_after(1);
    chk8("t7 no pulse on re-enable", bus.rise_o | bus.fall_o, 8'h00);

    // all pins fall together with limit 2 -> 2+2+1 edges
    bus.db_limit_i = 16'd2;
    bus.pin_i      = 8'h00;
    sample_after(5);
    chk8("t8 all fall", bus.fall_o, 8'h96);
    sample_after(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
